// File: rtl/rvo3_mem_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and default sizing.
package rvo3_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_DM   = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  // True while a transaction owns the memory port.
  function automatic logic arb_busy(arb_state_e s);
    return s != ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
//
// Handshake: a requester raises *_req with a stable payload and holds both
// until it sees a one-cycle *_ack (completion, *_rdata valid that cycle) or a
// one-cycle *_err (abort). On the memory side mem_req stays high with a
// stable payload until mem_ack is sampled high or the arbiter times out.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // instruction fetch
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;
  // load/store
  logic                dm_req;
  logic                dm_we;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic [DATA_W/8-1:0] dm_wstrb;
  logic                dm_ack;
  logic                dm_err;
  logic [DATA_W-1:0]   dm_rdata;
  // shared memory port
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  // Arbiter view.
  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
           mem_ack, mem_rdata,
    output if_ack, if_err, if_rdata, dm_ack, dm_err, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Requester / memory view.
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
           mem_ack, mem_rdata,
    input  if_ack, if_err, if_rdata, dm_ack, dm_err, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Wait counter for an outstanding memory transaction. expired is raised in the
// busy cycle whose missing ack makes the count reach TIMEOUT, so the owner is
// released after exactly TIMEOUT busy cycles.
module mem_arb_timer
  import rvo3_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt;

  // Count busy cycles without an ack; restart on every new grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = enable && !clear && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs load/store) onto one memory
// port. Data accesses win by default; after STARVE_MAX consecutive data
// grants with a fetch waiting, the fetch is granted. Each transaction is
// aborted with an err pulse if memory does not ack within TIMEOUT cycles.
module mem_arbiter
  import rvo3_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output arb_state_e    dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SC_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  arb_state_e state;
  arb_state_e state_nxt;

  logic [SC_W-1:0]   starve_cnt;
  logic              starve_full;
  logic              dm_win;
  logic              if_win;
  logic              busy;
  logic              timer_clear;
  logic              timer_en;
  logic              expired;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              if_err_q;
  logic              dm_err_q;

  // starve_cnt saturates at STARVE_MAX, so "not full" is "below STARVE_MAX"
  // and the two win terms are mutually exclusive.
  assign starve_full = (starve_cnt == SC_W'(STARVE_MAX));
  assign dm_win      = bus.dm_req && (!bus.if_req || !starve_full);
  assign if_win      = bus.if_req && (!bus.dm_req || starve_full);
  assign busy        = arb_busy(state);
  assign timer_en    = busy && !bus.mem_ack;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: grant from idle, release on ack (ack beats timeout) or expiry.
  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (dm_win) begin
          state_nxt   = ARB_DM;
          timer_clear = 1'b1;
        end else if (if_win) begin
          state_nxt   = ARB_IF;
          timer_clear = 1'b1;
        end
      end
      ARB_IF, ARB_DM: begin
        if (bus.mem_ack || expired) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Capture the winner's payload at grant; held untouched while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state == ARB_IDLE) begin
      if (dm_win) begin
        addr_q  <= bus.dm_addr;
        we_q    <= bus.dm_we;
        wdata_q <= bus.dm_wdata;
        wstrb_q <= bus.dm_wstrb;
      end else if (if_win) begin
        addr_q  <= bus.if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  // Count data grants that bypassed a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (dm_win && bus.if_req) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end else if (if_win) begin
        starve_cnt <= '0;
      end
    end
  end

  // One-cycle abort pulse to the owner of a timed-out transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_err_q <= 1'b0;
      dm_err_q <= 1'b0;
    end else begin
      if_err_q <= (state == ARB_IF) && expired;
      dm_err_q <= (state == ARB_DM) && expired;
    end
  end

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  assign bus.mem_req   = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  assign bus.if_ack    = bus.mem_ack && (state == ARB_IF);
  assign bus.dm_ack    = bus.mem_ack && (state == ARB_DM);
  assign bus.if_err    = if_err_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;

  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change on the falling edge; outputs
// are checked 1ns later, well away from the rising edge.
module tb_mem_arbiter;
  import rvo3_mem_pkg::*;

  logic       clk;
  logic       rst;
  arb_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_a;
  int          n;
  int          bc;
  int          ack_seen;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_arbiter #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .STARVE_MAX (4),
    .TIMEOUT    (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_wstrb  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // ---------------- reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", dbg_state, ARB_IDLE);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_wstrb", bus.mem_wstrb, 0);
    check("rst_if_err", bus.if_err, 0);
    check("rst_dm_err", bus.dm_err, 0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- fetch only, ack on 4th busy cycle
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h1000;
    #1;
    check("t1_idle", dbg_state, ARB_IDLE);
    check("t1_no_req_yet", bus.mem_req, 0);
    @(negedge clk); #1;
    check("t1_state", dbg_state, ARB_IF);
    check("t1_mem_req", bus.mem_req, 1);
    check("t1_mem_addr", bus.mem_addr, 64'h1000);
    check("t1_mem_we", bus.mem_we, 0);
    check("t1_mem_wstrb", bus.mem_wstrb, 0);
    check("t1_if_ack_early", bus.if_ack, 0);
    repeat (2) begin
      @(negedge clk); #1;
      check("t1_wait_if_ack", bus.if_ack, 0);
      check("t1_addr_stable", bus.mem_addr, 64'h1000);
    end
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hCAFE_F00D;
    #1;
    check("t1_if_ack", bus.if_ack, 1);
    check("t1_if_rdata", bus.if_rdata, 64'hCAFE_F00D);
    check("t1_dm_ack", bus.dm_ack, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    #1;
    check("t1_back_idle", dbg_state, ARB_IDLE);
    check("t1_req_low", bus.mem_req, 0);
    check("t1_if_ack_low", bus.if_ack, 0);

    // ---------------- simultaneous fetch + store: store first, then fetch
    @(negedge clk);
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h1100;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 64'h2000;
    bus.dm_wdata = 64'hDEAD;
    bus.dm_wstrb = 8'hFF;
    @(negedge clk);
    bus.dm_req = 1'b0;  // dropping req must not cancel the store
    #1;
    check("t2_state_dm", dbg_state, ARB_DM);
    check("t2_mem_addr", bus.mem_addr, 64'h2000);
    check("t2_mem_we", bus.mem_we, 1);
    check("t2_mem_wdata", bus.mem_wdata, 64'hDEAD);
    check("t2_mem_wstrb", bus.mem_wstrb, 8'hFF);
    @(negedge clk); #1;
    check("t2_still_dm", dbg_state, ARB_DM);
    check("t2_still_req", bus.mem_req, 1);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    check("t2_dm_ack", bus.dm_ack, 1);
    check("t2_if_ack_off", bus.if_ack, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("t2_gap_idle", dbg_state, ARB_IDLE);
    check("t2_gap_req", bus.mem_req, 0);
    @(negedge clk); #1;
    check("t2_state_if", dbg_state, ARB_IF);
    check("t2_if_addr", bus.mem_addr, 64'h1100);
    check("t2_if_we", bus.mem_we, 0);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    check("t2_if_ack", bus.if_ack, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    #1;
    check("t2_end_idle", dbg_state, ARB_IDLE);

    // ---------------- continuous contention: 4 data grants then 1 fetch
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back((k % 5 == 4) ? 64'h3000 : 64'h4000);
    end
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h3000;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 64'h4000;
    bc = 0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.mem_req) bc++;
      else bc = 0;
      if (bus.mem_req && bc == 1) begin
        exp_a = exp_q.pop_front();
        check("t3_grant_addr", bus.mem_addr, exp_a);
        check("t3_grant_we", bus.mem_we, 0);
      end
      bus.mem_ack = bus.mem_req && (bc == 2);
    end
    check("t3_grants_left", exp_q.size(), 0);
    @(negedge clk);
    bus.if_req  = 1'b0;
    bus.dm_req  = 1'b0;
    bus.mem_ack = 1'b1;
    #1;
    check("t3_last_if_ack", bus.if_ack, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("t3_end_idle", dbg_state, ARB_IDLE);

    // ---------------- load never acked: abort after 255 busy cycles
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 64'h5000;
    n = 0;
    ack_seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!bus.mem_req) break;
      n++;
      if (bus.dm_ack || bus.dm_err) ack_seen++;
    end
    check("t4_busy_cycles", n, 255);
    check("t4_no_early_resp", ack_seen, 0);
    check("t4_dm_err", bus.dm_err, 1);
    check("t4_dm_ack", bus.dm_ack, 0);
    check("t4_state_idle", dbg_state, ARB_IDLE);
    bus.dm_req = 1'b0;
    @(negedge clk); #1;
    check("t4_err_pulse", bus.dm_err, 0);
    check("t4_stay_idle", dbg_state, ARB_IDLE);

    // ---------------- reset in the middle of a store
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 64'h6000;
    bus.dm_wdata = 64'h55;
    bus.dm_wstrb = 8'h0F;
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h7000;
    @(negedge clk); #1;
    check("t5_state_dm", dbg_state, ARB_DM);
    check("t5_mem_addr", bus.mem_addr, 64'h6000);
    #1;
    rst = 1'b0;
    #1;
    check("t5_rst_req", bus.mem_req, 0);
    check("t5_rst_state", dbg_state, ARB_IDLE);
    check("t5_rst_addr", bus.mem_addr, 0);
    check("t5_rst_dm_ack", bus.dm_ack, 0);
    check("t5_rst_dm_err", bus.dm_err, 0);
    @(negedge clk);
    bus.dm_req = 1'b0;
    rst        = 1'b1;
    #1;
    check("t5_rel_idle", dbg_state, ARB_IDLE);
    check("t5_no_err", bus.dm_err, 0);
    @(negedge clk); #1;
    check("t5_if_granted", dbg_state, ARB_IF);
    check("t5_if_addr", bus.mem_addr, 64'h7000);
    check("t5_if_req", bus.mem_req, 1);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    check("t5_if_ack", bus.if_ack, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    #1;
    check("t5_end_idle", dbg_state, ARB_IDLE);

    // ---------------- stray ack while idle
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    check("t6_if_ack", bus.if_ack, 0);
    check("t6_dm_ack", bus.dm_ack, 0);
    @(negedge clk); #1;
    check("t6_state", dbg_state, ARB_IDLE);
    check("t6_mem_req", bus.mem_req, 0);
    bus.mem_ack = 1'b0;

    // ---------------- ack on the timeout cycle wins over the abort
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8000;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!bus.mem_req) break;
      n++;
      if (n == 255) begin
        bus.mem_ack = 1'b1;
        #1;
        check("t7_if_ack", bus.if_ack, 1);
        check("t7_if_err_same", bus.if_err, 0);
        break;
      end
    end
    check("t7_busy_cycles", n, 255);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    #1;
    check("t7_no_err", bus.if_err, 0);
    check("t7_idle", dbg_state, ARB_IDLE);
    check("t7_if_ack_low", bus.if_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
